// File: rtl/snapshot_capture_ctrl_if.sv
// Snapshot capture bus: control word and samples in, BRAM write port and status out.
// Latency: n/a (signal bundle only).
// Backpressure: none; the BRAM write port always accepts.
interface snapshot_capture_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [31:0]       ctrl;
  logic [DATA_W-1:0] din;
  logic              we_in;
  logic              trig;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;
  logic              bram_we;
  logic [31:0]       status;

  // Driver side: software register + sample source, observes BRAM port and status
  modport master (
    output ctrl, din, we_in, trig,
    input  bram_addr, bram_data, bram_we, status
  );

  // Capture controller side
  modport slave (
    input  ctrl, din, we_in, trig,
    output bram_addr, bram_data, bram_we, status
  );
endinterface

// File: rtl/snapshot_capture_ctrl.sv
// Snapshot capture sequencer: arm on ctrl[0] edge, wait for trigger, stream samples into BRAM.
// Latency: sample in cycle c appears on bram_* and status in cycle c+1; arm edge to ARMED is 1 cycle.
// Backpressure: none; the BRAM always accepts. Optional circular mode via macro SNAPSHOT_CIRC_EN.
module snapshot_capture_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                    user_clk,
  input  logic                    user_rst_n,
  snapshot_capture_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LAST_CNT = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};

  state_t            state_q, state_d;
  logic              arm_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;

  logic arm_pulse;
  logic qual;
  logic fill_done;
  logic busy;

  assign arm_pulse = bus.ctrl[0] & ~arm_q;
  assign qual      = bus.ctrl[2] ? bus.we_in : 1'b1;
  // This cycle's qualified write is the one that fills the buffer
  assign fill_done = qual && (count_q == LAST_CNT);
  assign busy      = (state_q == S_ARMED) || (state_q == S_CAPTURE);

`ifdef SNAPSHOT_CIRC_EN
  logic wrapped_q, wrapped_d;
  logic stop_q;
  logic stop_pulse;
  logic circ;

  assign circ       = bus.ctrl[3];
  assign stop_pulse = bus.ctrl[4] & ~stop_q;

  logic [26:0] unused_ctrl_bits;
  assign unused_ctrl_bits = bus.ctrl[31:5];
`else
  logic [28:0] unused_ctrl_bits;
  assign unused_ctrl_bits = bus.ctrl[31:3];
`endif

  // Edge detectors, FSM state and the registered BRAM write port / status sources
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q <= S_IDLE;
      arm_q   <= 1'b0;
      count_q <= '0;
      ptr_q   <= '0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
`ifdef SNAPSHOT_CIRC_EN
      wrapped_q <= 1'b0;
      stop_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      arm_q   <= bus.ctrl[0];
      count_q <= count_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
`ifdef SNAPSHOT_CIRC_EN
      wrapped_q <= wrapped_d;
      stop_q    <= bus.ctrl[4];
`endif
    end
  end

  // Next-state: arm/trigger sequencing and per-sample write generation
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    done_d  = done_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
`ifdef SNAPSHOT_CIRC_EN
    wrapped_d = wrapped_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        // A fresh arm edge restarts from an empty buffer
        if (arm_pulse) begin
          state_d = S_ARMED;
          count_d = '0;
          ptr_d   = '0;
          done_d  = 1'b0;
`ifdef SNAPSHOT_CIRC_EN
          wrapped_d = 1'b0;
`endif
        end
      end

      S_ARMED: begin
        // The trigger cycle's own sample is not captured
        if (!bus.ctrl[1] || bus.trig) begin
          state_d = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        if (qual) begin
          we_d   = 1'b1;
          addr_d = ptr_q;
          data_d = bus.din;
          ptr_d  = ptr_q + 1'b1;
          // Count saturates at full depth; in circular mode it stays there
          if (count_q != FULL_CNT) begin
            count_d = count_q + 1'b1;
          end
        end
`ifdef SNAPSHOT_CIRC_EN
        if (qual && circ && (ptr_q == LAST_PTR)) begin
          wrapped_d = 1'b1;
        end
        if ((fill_done && !circ) || stop_pulse) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
`else
        if (fill_done) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Status word assembled from registered state only, so it moves with bram_*
  always_comb begin
    bus.status     = '0;
    bus.status[31] = done_q;
    bus.status[30] = busy;
`ifdef SNAPSHOT_CIRC_EN
    bus.status[29]         = wrapped_q;
    // Low bits follow the write pointer, i.e. the oldest sample once wrapped
    bus.status[ADDR_W:0]   = {count_q[ADDR_W], ptr_q};
`else
    bus.status[ADDR_W:0]   = count_q;
`endif
  end

  assign bus.bram_addr = addr_q;
  assign bus.bram_data = data_q;
  assign bus.bram_we   = we_q;

endmodule

// File: doc/snapshot_capture_ctrl.md
# snapshot_capture_ctrl

Capture sequencer that sits directly downstream of the snapshot control register (the OPB-to-user register driving a 32-bit control word into the `user_clk` domain). It decodes the control word and arms on command. It waits for an immediate or external trigger, then streams qualified samples into a snapshot BRAM write port. It reports done, busy and word count on a 32-bit status word read back by software.

## Interface
Parameters:
- `ADDR_W`, 10: BRAM address width; capture depth = 2^ADDR_W words
- `DATA_W`, 32: sample and BRAM data width

Ports:
- `user_clk`, in, 1: the single clock; the control word is already in this domain
- `user_rst_n`, in, 1: reset, asynchronous, active-low
- `ctrl`, in, 32: control word from the register. Bit [0] arm, [1] trig_sel (0 immediate, 1 external), [2] we_sel (0 every cycle, 1 `we_in`), [3] circ, [4] stop. Other bits are ignored.
- `din`, in, DATA_W: sample data
- `we_in`, in, 1: external sample qualifier
- `trig`, in, 1: external trigger, level-sampled
- `bram_addr`, out, ADDR_W: BRAM write address, registered
- `bram_data`, out, DATA_W: BRAM write data, registered
- `bram_we`, out, 1: BRAM write enable, registered
- `status`, out, 32: [31] done, [30] busy, [29] wrapped, [ADDR_W:0] count (words written). Other bits read 0.

## Operation
- States: IDLE, ARMED, CAPTURE, DONE. IDLE is the reset state.
- Arm pulse = `ctrl[0]` & ~arm_d, where arm_d is `ctrl[0]` registered. Holding bit 0 high never re-arms.
- IDLE or DONE + arm pulse -> ARMED. On this transition: count := 0, done := 0, wrapped := 0.
- Arm pulse in ARMED or CAPTURE is ignored.
- ARMED -> CAPTURE when trig_sel=0 (next edge) or when trig_sel=1 and `trig`=1.
- CAPTURE, each cycle:
  - qual = (we_sel ? `we_in` : 1).
  - If qual: write `din` at address count[ADDR_W-1:0], then count++.
  - When a write makes count = 2^ADDR_W: -> DONE. count saturates at 2^ADDR_W.
- DONE: done=1; no writes.
- busy = state is ARMED or CAPTURE.
- `ctrl` bits [1]/[2] are sampled live each cycle. Software must not change them mid-capture; no checking is done.
- Reset mid-capture: everything returns to reset values immediately. The partial BRAM contents are left as they are.

## Timing
- Reset values: `bram_addr`=0, `bram_data`=0, `bram_we`=0, `status`=0, state=IDLE, arm_d=0.
- `ctrl[0]` rises in cycle k -> ARMED in cycle k+1.
- Immediate trigger -> CAPTURE in cycle k+2. First `din` sampled in cycle k+2 appears on `bram_*` in cycle k+3.
- External trigger seen high in ARMED cycle j -> CAPTURE from cycle j+1. The sample in cycle j is not written.
- Write latency: `din`/qual in cycle c -> `bram_we`/`bram_addr`/`bram_data` valid in cycle c+1.
- `status` is registered and updated on the same edge as the `bram_*` outputs.
- done=1 and count=2^ADDR_W are visible in the same cycle as the final `bram_we`. busy drops in that cycle too.

## Configuration
- `SNAPSHOT_CIRC_EN` defined:
  - With `ctrl[3]`=1, CAPTURE does not stop at full. The address wraps 2^ADDR_W-1 -> 0, count holds at 2^ADDR_W, and wrapped := 1 on the first wrap.
  - A `ctrl[4]` rising edge in CAPTURE -> DONE after the current cycle's write completes.
  - `status[ADDR_W-1:0]` then reports the next write address, i.e. the oldest sample.
- Not defined: `ctrl[3]` and `ctrl[4]` are ignored, `status[29]` reads 0, and capture always stops at full.

## Test plan
- Reset with `user_rst_n`=0 mid-sequence -> all outputs 0, state IDLE; the next arm works normally.
- ADDR_W=4, `ctrl`=0x1 (immediate, every cycle), ramp `din`=0..15:
  - 16 writes at addresses 0..15 with data 0..15;
  - `status`=0x80000010 in the cycle of the last write.
- `ctrl`=0x3, `trig` low for 20 cycles, then high:
  - busy=1 and no `bram_we` while waiting;
  - first written data is the `din` from the cycle after `trig` was seen.
- `ctrl`=0x5 with `we_in` toggling 1,0,1,0:
  - only qualified samples are written, at consecutive addresses;
  - count increments by 1 per written sample.
- `ctrl[0]` held high after DONE -> no re-arm. Toggling bit 0 to 0 and back to 1 -> done clears, count=0, ARMED.
- `SNAPSHOT_CIRC_EN`, ADDR_W=4, `ctrl`=0x9 for 20 samples, then set bit 4:
  - wrapped=1 and done=1;
  - `status[3:0]`=4, the oldest-sample address.
